// File: rtl/adbg_jsp_apb_host.sv
// APB master that polls a JTAG serial port (16550-style LSR at address 5,
// RBR/THR at address 0). It moves bytes between one-byte tx/rx buffers and
// the slave. A poll that finds no work is followed by an idle gap before
// the next poll.
`timescale 1ns/1ps
module adbg_jsp_apb_host #(
    parameter int unsigned POLL_GAP = 4
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [2:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       err_o
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        POLL_SETUP  = 3'd1,
        POLL_ACCESS = 3'd2,
        RD_SETUP    = 3'd3,
        RD_ACCESS   = 3'd4,
        WR_SETUP    = 3'd5,
        WR_ACCESS   = 3'd6,
        GAP         = 3'd7
    } state_t;

    localparam logic       DIR_READ  = 1'b0;
    localparam logic       DIR_WRITE = 1'b1;
    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_LSR  = 3'd5;
    // Last GAP count value; POLL_GAP=0 still spends one cycle in GAP.
    localparam logic [7:0] GAP_LAST  = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] gap_cnt_r;
    logic       last_dir_r;
    logic [7:0] tx_buf_r;
    logic       tx_ready_r;
    logic [7:0] rx_buf_r;
    logic       rx_valid_r;
    logic       err_r;

    logic       dr_s;
    logic       thre_s;
    logic       rd_ok_s;
    logic       wr_ok_s;
    logic       rd_done_s;
    logic       wr_done_s;
    logic       access_done_s;

    // An erroring poll is treated as "nothing ready", so its data never steers the FSM.
    assign dr_s          = PRDATA[0] & ~PSLVERR;
    assign thre_s        = PRDATA[5] & ~PSLVERR;
    assign rd_ok_s       = dr_s & ~rx_valid_r;
    assign wr_ok_s       = thre_s & ~tx_ready_r;
    assign rd_done_s     = (state_r == RD_ACCESS) & PREADY;
    assign wr_done_s     = (state_r == WR_ACCESS) & PREADY;
    assign access_done_s = PREADY & ((state_r == POLL_ACCESS) | (state_r == RD_ACCESS) |
                                     (state_r == WR_ACCESS));

    // Next-state decision: poll, arbitrate read/write on ties, otherwise gap.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:        state_nxt_s = POLL_SETUP;
            POLL_SETUP:  state_nxt_s = POLL_ACCESS;
            POLL_ACCESS: begin
                if (PREADY) begin
                    if (rd_ok_s && wr_ok_s) begin
                        state_nxt_s = (last_dir_r == DIR_WRITE) ? RD_SETUP : WR_SETUP;
                    end else if (rd_ok_s) begin
                        state_nxt_s = RD_SETUP;
                    end else if (wr_ok_s) begin
                        state_nxt_s = WR_SETUP;
                    end else begin
                        state_nxt_s = GAP;
                    end
                end else begin
                    state_nxt_s = POLL_ACCESS;
                end
            end
            RD_SETUP:    state_nxt_s = RD_ACCESS;
            RD_ACCESS: begin
                if (PREADY) begin
                    state_nxt_s = POLL_SETUP;
                end else begin
                    state_nxt_s = RD_ACCESS;
                end
            end
            WR_SETUP:    state_nxt_s = WR_ACCESS;
            WR_ACCESS: begin
                if (PREADY) begin
                    state_nxt_s = POLL_SETUP;
                end else begin
                    state_nxt_s = WR_ACCESS;
                end
            end
            GAP: begin
                if (gap_cnt_r >= GAP_LAST) begin
                    state_nxt_s = POLL_SETUP;
                end else begin
                    state_nxt_s = GAP;
                end
            end
            default:     state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) state_r <= IDLE;
        else          state_r <= state_nxt_s;
    end

    // Gap counter: counts while staying in GAP, zero everywhere else.
    always_ff @(posedge PCLK) begin
        if (!PRESETn)                                       gap_cnt_r <= 8'd0;
        else if ((state_r == GAP) && (state_nxt_s == GAP))  gap_cnt_r <= gap_cnt_r + 8'd1;
        else                                                gap_cnt_r <= 8'd0;
    end

    // APB outputs registered from the next state so they line up with state_r.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= 3'd0;
            PWDATA  <= 8'd0;
        end else begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= 3'd0;
            PWDATA  <= 8'd0;
            case (state_nxt_s)
                POLL_SETUP, POLL_ACCESS: begin
                    PSEL    <= 1'b1;
                    PENABLE <= (state_nxt_s == POLL_ACCESS);
                    PADDR   <= ADDR_LSR;
                end
                RD_SETUP, RD_ACCESS: begin
                    PSEL    <= 1'b1;
                    PENABLE <= (state_nxt_s == RD_ACCESS);
                    PADDR   <= ADDR_DATA;
                end
                WR_SETUP, WR_ACCESS: begin
                    PSEL    <= 1'b1;
                    PENABLE <= (state_nxt_s == WR_ACCESS);
                    PWRITE  <= 1'b1;
                    PADDR   <= ADDR_DATA;
                    PWDATA  <= tx_buf_r;
                end
                default: begin
                    PSEL    <= 1'b0;
                end
            endcase
        end
    end

    // Remember which direction was served last for tie arbitration.
    always_ff @(posedge PCLK) begin
        if (!PRESETn)       last_dir_r <= DIR_WRITE;
        else if (rd_done_s) last_dir_r <= DIR_READ;
        else if (wr_done_s) last_dir_r <= DIR_WRITE;
    end

    // tx buffer: capture when empty, drain on write completion (even on error).
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            tx_buf_r   <= 8'd0;
            tx_ready_r <= 1'b1;
        end else if (tx_valid_i && tx_ready_r) begin
            tx_buf_r   <= tx_data_i;
            tx_ready_r <= 1'b0;
        end else if (wr_done_s) begin
            tx_ready_r <= 1'b1;
        end
    end

    // rx buffer: load on clean read completion, release on consumer handshake.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            rx_buf_r   <= 8'd0;
            rx_valid_r <= 1'b0;
        end else if (rd_done_s && !PSLVERR) begin
            rx_buf_r   <= PRDATA;
            rx_valid_r <= 1'b1;
        end else if (rx_valid_r && rx_ready_i) begin
            rx_valid_r <= 1'b0;
        end
    end

    // Sticky slave-error flag.
    always_ff @(posedge PCLK) begin
        if (!PRESETn)                      err_r <= 1'b0;
        else if (access_done_s && PSLVERR) err_r <= 1'b1;
    end

    assign tx_ready_o = tx_ready_r;
    assign rx_data_o  = rx_buf_r;
    assign rx_valid_o = rx_valid_r;
    assign err_o      = err_r;

endmodule

// File: tb/tb_adbg_jsp_apb_host.sv
// Directed bench for adbg_jsp_apb_host with a small APB slave model and a
// transfer log used to check ordering, gaps and signal stability.
`timescale 1ns/1ps
module tb_adbg_jsp_apb_host;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       PSEL, PENABLE, PWRITE;
    logic [2:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA = 8'd0;
    logic       PREADY = 1'b0;
    logic       PSLVERR = 1'b0;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       err_o;

    adbg_jsp_apb_host #(.POLL_GAP(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .err_o(err_o)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;

    // slave configuration
    logic [7:0] lsr = 8'h00;
    logic [7:0] rbr = 8'h00;
    int         wait_cfg = 0;
    logic       slverr_rd = 1'b0;

    // monitor state
    int         wait_cnt = 0;
    int         n_xfer = 0;
    logic [2:0] addr_log [0:1023];
    logic       wr_log   [0:1023];
    logic [7:0] wd_log   [0:1023];
    int         idle_run = 0;
    int         last_gap = -1;
    int         stab_bad = 0;
    logic [2:0] s_addr = 3'd0;
    logic       s_wr = 1'b0;
    logic [7:0] s_wd = 8'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    function automatic int count_x(input int from, input logic [2:0] a, input logic w);
        int c = 0;
        for (int i = from; i < n_xfer; i++)
            if (addr_log[i] == a && wr_log[i] == w) c++;
        return c;
    endfunction

    // Slave model and bus monitor, evaluated mid-cycle.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (wait_cnt < wait_cfg) begin
                PREADY = 1'b0;
                wait_cnt++;
            end else begin
                PREADY = 1'b1;
            end
            if (PADDR !== s_addr || PWRITE !== s_wr || PWDATA !== s_wd) stab_bad++;
        end else begin
            PREADY   = 1'b0;
            wait_cnt = 0;
            if (PSEL) begin
                s_addr = PADDR;
                s_wr   = PWRITE;
                s_wd   = PWDATA;
            end
        end
        PRDATA  = (PADDR == 3'd5) ? lsr : rbr;
        PSLVERR = PSEL && PENABLE && slverr_rd && (PADDR == 3'd0) && !PWRITE;
        if (PSEL && PENABLE && PREADY && n_xfer < 1024) begin
            addr_log[n_xfer] = PADDR;
            wr_log[n_xfer]   = PWRITE;
            wd_log[n_xfer]   = PWDATA;
            n_xfer++;
        end
        if (PSEL !== 1'b1) begin
            idle_run++;
        end else begin
            if (idle_run > 0) last_gap = idle_run;
            idle_run = 0;
        end
    end

    initial begin
        int base;
        int first;
        int nd;
        int mis;
        logic [3:0] pat;
        logic [7:0] wd0;
        logic found;

        PRESETn    = 1'b0;
        tx_data_i  = 8'h00;
        tx_valid_i = 1'b0;
        rx_ready_i = 1'b0;

        // reset values
        step(3);
        check("rst_psel",    PSEL,       1'b0);
        check("rst_penable", PENABLE,    1'b0);
        check("rst_pwrite",  PWRITE,     1'b0);
        check("rst_paddr",   PADDR,      3'd0);
        check("rst_pwdata",  PWDATA,     8'd0);
        check("rst_txrdy",   tx_ready_o, 1'b1);
        check("rst_rxvld",   rx_valid_o, 1'b0);
        check("rst_rxdata",  rx_data_o,  8'd0);
        check("rst_err",     err_o,      1'b0);

        // idle polling with LSR=0
        PRESETn = 1'b1;
        base = n_xfer;
        step(40);
        check("poll_seen",   (count_x(base, 3'd5, 1'b0) >= 3), 1'b1);
        check("poll_only",   n_xfer - base - count_x(base, 3'd5, 1'b0), 0);
        check("poll_gap",    last_gap, 4);
        check("idle_txrdy",  tx_ready_o, 1'b1);
        check("idle_rxvld",  rx_valid_o, 1'b0);

        // single read, no further reads while rx full
        rbr = 8'hA5;
        lsr = 8'h01;
        base = n_xfer;
        step(40);
        check("rd_count",    count_x(base, 3'd0, 1'b0), 1);
        check("rd_valid",    rx_valid_o, 1'b1);
        check("rd_data",     rx_data_o,  8'hA5);
        lsr = 8'h00;
        step(10);
        rx_ready_i = 1'b1;
        step(1);
        rx_ready_i = 1'b0;
        check("rd_pop",      rx_valid_o, 1'b0);

        // single write
        lsr = 8'h20;
        tx_data_i  = 8'h3C;
        tx_valid_i = 1'b1;
        base = n_xfer;
        step(1);
        tx_valid_i = 1'b0;
        check("wr_txfull",   tx_ready_o, 1'b0);
        step(40);
        check("wr_count",    count_x(base, 3'd0, 1'b1), 1);
        check("wr_nord",     count_x(base, 3'd0, 1'b0), 0);
        wd0 = 8'h00;
        for (int i = base; i < n_xfer; i++) if (wr_log[i]) wd0 = wd_log[i];
        check("wr_data",     wd0, 8'h3C);
        check("wr_txrdy",    tx_ready_o, 1'b1);

        // both ready, slow slave: read first then alternate
        lsr = 8'h00;
        rbr = 8'h96;
        wait_cfg   = 3;
        rx_ready_i = 1'b1;
        tx_data_i  = 8'h5A;
        tx_valid_i = 1'b1;
        step(2);
        base = n_xfer;
        lsr = 8'h21;
        nd = 0;
        for (int c = 0; c < 400 && nd < 4; c++) begin
            step(1);
            nd = count_x(base, 3'd0, 1'b0) + count_x(base, 3'd0, 1'b1);
        end
        check("alt_done",    (nd >= 4), 1'b1);
        first = -1;
        for (int i = base; i < n_xfer; i++)
            if (first < 0 && addr_log[i] == 3'd0) first = i;
        pat = 4'b0000;
        mis = 0;
        wd0 = 8'h00;
        for (int k = 0; k < 7; k++) begin
            if (first < 0 || first + k >= n_xfer) begin
                mis++;
            end else begin
                if (addr_log[first + k] != ((k % 2 == 0) ? 3'd0 : 3'd5)) mis++;
                if (k % 2 == 0) pat[k / 2] = wr_log[first + k];
                if (k == 2) wd0 = wd_log[first + k];
            end
        end
        check("alt_order",   pat[3:0] & 4'b0111, 4'b0010);
        check("alt_poll_between", mis, 0);
        check("alt_wdata",   wd0, 8'h5A);
        check("alt_stable",  stab_bad, 0);
        check("alt_err",     err_o, 1'b0);

        // slave error on read
        tx_valid_i = 1'b0;
        wait_cfg   = 0;
        lsr = 8'h20;
        step(30);
        check("drain_txrdy", tx_ready_o, 1'b1);
        rx_ready_i = 1'b0;
        step(1);
        check("drain_rx",    rx_valid_o, 1'b0);
        slverr_rd = 1'b1;
        lsr = 8'h01;
        base = n_xfer;
        step(40);
        check("slv_reads",   (count_x(base, 3'd0, 1'b0) >= 2), 1'b1);
        check("slv_err",     err_o, 1'b1);
        check("slv_rxvld",   rx_valid_o, 1'b0);
        slverr_rd = 1'b0;
        lsr = 8'h00;
        step(10);
        check("slv_sticky",  err_o, 1'b1);

        // reset during a stretched write access
        wait_cfg   = 20;
        lsr        = 8'h20;
        tx_data_i  = 8'hC3;
        tx_valid_i = 1'b1;
        step(1);
        tx_valid_i = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            step(1);
            if (PSEL && PENABLE && PWRITE) found = 1'b1;
        end
        check("mid_wr_found", found, 1'b1);
        PRESETn = 1'b0;
        step(1);
        check("mr_psel",    PSEL,       1'b0);
        check("mr_penable", PENABLE,    1'b0);
        check("mr_pwrite",  PWRITE,     1'b0);
        check("mr_paddr",   PADDR,      3'd0);
        check("mr_pwdata",  PWDATA,     8'd0);
        check("mr_txrdy",   tx_ready_o, 1'b1);
        check("mr_rxvld",   rx_valid_o, 1'b0);
        check("mr_rxdata",  rx_data_o,  8'd0);
        check("mr_err",     err_o,      1'b0);
        wait_cfg = 0;
        PRESETn  = 1'b1;
        base = n_xfer;
        step(30);
        check("mr_nodup",   count_x(base, 3'd0, 1'b1), 0);
        check("mr_polls",   (count_x(base, 3'd5, 1'b0) >= 2), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
